// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider: one quotient bit per clock through a single subtractor.
// The final quotient, remainder and divide-by-zero flag are held until the next accepted start.
module seq_divider #(
  parameter int unsigned size = 6
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [size-1:0] i_dividend,
  input  logic [size-1:0] i_divisor,
  input  logic            i_start,
  output logic [size-1:0] o_quotient,
  output logic [size-1:0] o_remainder,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_div_by_zero
);

  localparam int unsigned CntW = $clog2(size + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [CntW-1:0] r_count;
  logic [size-1:0] r_p;
  // Dividend shifts out at the MSB while quotient bits fill the vacated LSBs.
  logic [size-1:0] r_d;
  logic [size-1:0] r_divisor;
  logic [size-1:0] r_quotient;
  logic [size-1:0] r_remainder;
  logic            r_dbz;

  logic            w_accept;
  logic            w_div_zero;
  logic            w_last;
  logic            w_ge;
  logic [size:0]   w_p_shift;
  logic [size:0]   w_diff;
  logic [size-1:0] w_p_next;
  logic [size-1:0] w_d_next;

  assign w_div_zero = (i_divisor == '0);
  assign w_last     = (r_count == CntW'(1));

  // The shifted partial remainder is below 2*divisor, so the borrow bit of the difference
  // alone decides whether the subtraction is kept.
  assign w_p_shift = {r_p, r_d[size-1]};
  assign w_diff    = w_p_shift - {1'b0, r_divisor};
  assign w_ge      = ~w_diff[size];
  assign w_p_next  = w_ge ? w_diff[size-1:0] : w_p_shift[size-1:0];
  assign w_d_next  = {r_d[size-2:0], w_ge};

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_accept  = 1'b1;
          w_state_d = w_div_zero ? StDone : StRun;
        end else begin
          w_state_d = StIdle;
        end
      end
      StRun: begin
        if (w_last) begin
          w_state_d = StDone;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_count     <= '0;
      r_p         <= '0;
      r_d         <= '0;
      r_divisor   <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_p       <= '0;
        r_d       <= i_dividend;
        r_divisor <= i_divisor;
        r_dbz     <= w_div_zero;
        if (w_div_zero) begin
          r_count     <= '0;
          r_quotient  <= '1;
          r_remainder <= i_dividend;
        end else begin
          r_count <= CntW'(size);
        end
      end else if (r_state == StRun) begin
        r_p     <= w_p_next;
        r_d     <= w_d_next;
        r_count <= r_count - CntW'(1);
        if (w_last) begin
          r_quotient  <= w_d_next;
          r_remainder <= w_p_next;
        end
      end
    end
  end

  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_busy        = (r_state == StRun);
  assign o_done        = (r_state == StDone);
  assign o_div_by_zero = r_dbz;

endmodule
